sd_resp_rx: RTL and testbench
=============================

# sd_resp_rx

SD-card command-line response receiver. It sits directly downstream of the `command` transmitter on the shared CMD line. After a command has been sent, it is armed to hunt for the card's 48-bit response (R1/R3/R6/R7). It deserialises the response, checks framing and CRC7, and presents the index and argument to the init/control FSM with a one-cycle completion pulse.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum SD-clock strobes to wait for a start bit (N_CR).
- `clk`  in  1: system clock; all logic on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `sd_clk_en`  in  1: one-`clk` pulse marking an SD-clock rising edge; the only cycle on which `cmd_in` is sampled.
- `cmd_in`  in  1: CMD line input. It is already taken off the tristate, and it is high when idle because of the pull-up.
- `arm`  in  1: one-cycle pulse that starts response reception. It is ignored while `busy`=1.
- `crc_skip`  in  1: latched on `arm`. When it is 1, the CRC7 comparison is suppressed for that response (used for R3).
- `busy`  out  1: high from the cycle after an accepted `arm` through the cycle `resp_valid` pulses.
- `resp_valid`  out  1: one-cycle completion pulse. It fires on success, error or timeout.
- `resp_index`  out  6: bits [45:40] of the response.
- `resp_arg`  out  32: bits [39:8] of the response.
- `resp_timeout`  out  1: no start bit was seen within `TIMEOUT_CYCLES` strobes.
- `resp_crc_err`  out  1: received CRC7 does not match the computed CRC7.
- `resp_frame_err`  out  1: transmission bit (bit 46) is not 0, or end bit (bit 0) is not 1.

## Operation
- **IDLE**
  - On `arm` with `busy`=0: latch `crc_skip`, clear the wait counter, bit counter, CRC register and shift register, then go to WAIT_START.
- **WAIT_START**
  - On each `sd_clk_en`, if `cmd_in`=0, this is the start bit (bit 47). Set bit count to 1, feed 0 into the CRC, and go to SHIFT.
  - On each `sd_clk_en` with `cmd_in`=1, increment the wait counter.
  - If the counter reaches `TIMEOUT_CYCLES`, go to DONE with the timeout flag set.
- **SHIFT**
  - On each `sd_clk_en`, shift `cmd_in` in MSB-first and increment the bit count.
  - Bits 47..8 (the first 40 bits, start bit included) feed the serial CRC7. The polynomial is x^7+x^3+1 and the initial value is 0.
  - Bits 7..1 are captured as the received CRC.
  - When bit count reaches 48, go to DONE.
- **DONE** (one `clk` cycle)
  - Pulse `resp_valid`.
  - Drive `resp_index` and `resp_arg` from the shift register.
  - Set the flags:
    - `resp_frame_err` = (bit46≠0) | (bit0≠1).
    - `resp_crc_err` = !skip & (crc_rx≠crc_calc).
  - On timeout, `resp_index`/`resp_arg` are 0 and the CRC/frame flags are 0.
  - Return to IDLE.
- `resp_index`, `resp_arg` and the flags hold their values until the next DONE. All of them are cleared on `arm` acceptance.
- `arm` in DONE or in any non-IDLE state is dropped, not queued.
- Wait counter width is $clog2(`TIMEOUT_CYCLES`+1).
- The bit counter is 6 bits and saturates at 48; no wrap-around.

## Timing
- Reset values:
  - state IDLE.
  - `busy`=0.
  - `resp_valid`=0.
  - `resp_index`=0, `resp_arg`=0.
  - all flags 0.
- An `arm` accepted at cycle T gives `busy`=1 at T+1.
- `cmd_in` is sampled only in cycles where `sd_clk_en`=1. Between strobes, state holds.
- `resp_valid` asserts exactly 1 `clk` after the strobe that samples bit 0, or after the strobe that hits the timeout. `busy` falls in the cycle after that.
- If the timeout count is reached on the same strobe that sees `cmd_in`=0, the start bit wins.
- `rst` asserted mid-reception returns to IDLE immediately with no `resp_valid`. Partial data is discarded.
- `sd_clk_en` back-to-back on every `clk` is supported: full throughput, 1 bit per cycle.

## Configuration
- `SD_RESP_CRC_EN` defined: the CRC7 generator and comparison are built, and `resp_crc_err` behaves as above.
- `SD_RESP_CRC_EN` undefined: no CRC logic is built. Bits 7..1 are still shifted in but ignored. `resp_crc_err` is tied to 0 and `crc_skip` is unused.

## Test plan
- R7 `08 00 00 01 AA 13` sent 5 strobes after `arm`, `crc_skip`=0 -> `resp_valid`, `resp_index`=0x08, `resp_arg`=0x000001AA, all flags 0.
- Same frame with last byte 0x15 (CRC altered) -> `resp_crc_err`=1, `resp_frame_err`=0. Without `SD_RESP_CRC_EN` -> `resp_crc_err`=0.
- R3 `3F 00 FF 80 00 FF` with `crc_skip`=1 -> `resp_index`=0x3F, `resp_arg`=0x00FF8000, flags 0.
- `cmd_in` held high for 64 strobes after `arm` -> `resp_valid` with `resp_timeout`=1 one `clk` after the 64th strobe. A start bit on the 64th strobe instead -> no timeout, reception proceeds.
- Final bit sampled as 0 (end bit error) -> `resp_frame_err`=1.
- `rst` pulsed after 20 bits -> `busy`=0 and no `resp_valid`. Then re-`arm` with a clean R7 -> correct response.

Source files
------------

// File: rtl/sd_resp_rx.sv
// sd_resp_rx: hunts for and deserialises the 48-bit SD CMD-line response (R1/R3/R6/R7), checking framing and (optionally) CRC7.
// Latency: resp_valid pulses one clk after the strobe that samples the end bit, or the strobe that exhausts the start-bit wait.
// Backpressure: none; arm is dropped while busy, and results hold until the next completion.
// Optional feature macro: SD_RESP_CRC_EN builds the CRC7 generator and comparison (otherwise resp_crc_err is tied low).
module sd_resp_rx #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sd_clk_en,
    input  logic        cmd_in,
    input  logic        arm,
    input  logic        crc_skip,
    output logic        busy,
    output logic        resp_valid,
    output logic [5:0]  resp_index,
    output logic [31:0] resp_arg,
    output logic        resp_timeout,
    output logic        resp_crc_err,
    output logic        resp_frame_err
);

    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WCW-1:0]  wait_cnt;
    logic [5:0]      bit_cnt;
    // Holds response bits 46 downwards; the start bit is known to be 0 and is not stored.
    logic [45:0]     shreg;

    logic            arm_acc;
    logic            start_seen;
    logic            wait_expired;
    logic            shift_bit;
    logic            last_bit;
    // Response bits 46..0 as they stand on the strobe that samples the end bit.
    logic [46:0]     frame;
    logic            crc_err_nxt;

    assign arm_acc      = (state == ST_IDLE) && arm;
    assign start_seen   = (state == ST_WAIT) && sd_clk_en && !cmd_in;
    // The start bit takes precedence over a timeout landing on the same strobe.
    assign wait_expired = (state == ST_WAIT) && sd_clk_en && cmd_in && (wait_cnt == WAIT_LAST);
    assign shift_bit    = (state == ST_SHIFT) && sd_clk_en;
    assign last_bit     = shift_bit && (bit_cnt == 6'd47);
    assign frame        = {shreg, cmd_in};

    assign busy       = (state != ST_IDLE);
    assign resp_valid = (state == ST_DONE);

`ifdef SD_RESP_CRC_EN
    logic       skip_q;
    logic [6:0] crc;

    // One serial step of CRC7, generator x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Latch the per-response skip request when reception is armed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            skip_q <= 1'b0;
        else if (arm_acc)
            skip_q <= crc_skip;
    end

    // Run CRC7 over bits 47..8: the start bit, then the next 39 shifted bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            crc <= 7'h00;
        else if (arm_acc)
            crc <= 7'h00;
        else if (start_seen)
            crc <= crc7_step(crc, 1'b0);
        else if (shift_bit && (bit_cnt <= 6'd39))
            crc <= crc7_step(crc, cmd_in);
    end

    assign crc_err_nxt = !skip_q && (frame[7:1] != crc);
`else
    logic unused_crc_skip;
    assign unused_crc_skip = crc_skip;
    assign crc_err_nxt     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (arm)
                    state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (start_seen)
                    state_nxt = ST_SHIFT;
                else if (wait_expired)
                    state_nxt = ST_DONE;
            end
            ST_SHIFT: begin
                if (last_bit)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Count idle-high strobes while waiting for the start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (arm_acc)
            wait_cnt <= '0;
        else if ((state == ST_WAIT) && sd_clk_en && cmd_in && !wait_expired)
            wait_cnt <= wait_cnt + WCW'(1);
    end

    // Count received bits, start bit included; saturates at 48.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bit_cnt <= 6'd0;
        else if (arm_acc)
            bit_cnt <= 6'd0;
        else if (start_seen)
            bit_cnt <= 6'd1;
        else if (shift_bit && (bit_cnt < 6'd48))
            bit_cnt <= bit_cnt + 6'd1;
    end

    // Deserialise MSB-first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            shreg <= '0;
        else if (arm_acc)
            shreg <= '0;
        else if (shift_bit)
            shreg <= {shreg[44:0], cmd_in};
    end

    // Result registers: cleared on arm, loaded as the FSM enters DONE, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_index     <= 6'd0;
            resp_arg       <= 32'd0;
            resp_timeout   <= 1'b0;
            resp_crc_err   <= 1'b0;
            resp_frame_err <= 1'b0;
        end else if (arm_acc) begin
            resp_index     <= 6'd0;
            resp_arg       <= 32'd0;
            resp_timeout   <= 1'b0;
            resp_crc_err   <= 1'b0;
            resp_frame_err <= 1'b0;
        end else if (wait_expired) begin
            resp_index     <= 6'd0;
            resp_arg       <= 32'd0;
            resp_timeout   <= 1'b1;
            resp_crc_err   <= 1'b0;
            resp_frame_err <= 1'b0;
        end else if (last_bit) begin
            resp_index     <= frame[45:40];
            resp_arg       <= frame[39:8];
            resp_timeout   <= 1'b0;
            resp_crc_err   <= crc_err_nxt;
            resp_frame_err <= frame[46] | ~frame[0];
        end
    end

endmodule

// File: tb/tb_sd_resp_rx.sv
module tb_sd_resp_rx;

`ifdef SD_RESP_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sd_clk_en = 1'b0;
    logic        cmd_in = 1'b1;
    logic        arm = 1'b0;
    logic        crc_skip = 1'b0;
    logic        busy;
    logic        resp_valid;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic        resp_timeout;
    logic        resp_crc_err;
    logic        resp_frame_err;

    int n_pass = 0;
    int n_total = 0;

    sd_resp_rx #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .sd_clk_en(sd_clk_en), .cmd_in(cmd_in),
        .arm(arm), .crc_skip(crc_skip), .busy(busy), .resp_valid(resp_valid),
        .resp_index(resp_index), .resp_arg(resp_arg), .resp_timeout(resp_timeout),
        .resp_crc_err(resp_crc_err), .resp_frame_err(resp_frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1, via long division.
    function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
        logic [46:0] rem;
        rem = {msg, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (rem[i]) rem = rem ^ (47'h89 << (i - 7));
        return rem[6:0];
    endfunction

    // One SD strobe after 'gap' idle clocks of random, to-be-ignored line noise.
    task automatic strobe(input logic b, input int gap);
        sd_clk_en = 1'b0;
        for (int g = 0; g < gap; g++) begin
            cmd_in = 1'($urandom);
            tick();
        end
        sd_clk_en = 1'b1;
        cmd_in = b;
        tick();
        sd_clk_en = 1'b0;
        cmd_in = 1'b1;
    endtask

    task automatic do_arm(input logic skip);
        arm = 1'b1;
        crc_skip = skip;
        tick();
        arm = 1'b0;
        crc_skip = 1'($urandom);
        chk("busy_after_arm", 64'(busy), 64'd1);
        chk("cleared_on_arm", 64'({resp_index, resp_timeout, resp_crc_err, resp_frame_err}) | 64'(resp_arg), 64'd0);
    endtask

    task automatic send_bits(input logic [47:0] f, input int from_bit, input int to_bit, input int maxgap);
        for (int i = from_bit; i >= to_bit; i--)
            strobe(f[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic rx_frame(input logic [47:0] f, input logic skip, input int delay, input int maxgap);
        do_arm(skip);
        for (int i = 0; i < delay; i++) strobe(1'b1, 0);
        send_bits(f, 47, 0, maxgap);
    endtask

    // Expects the completion pulse now, then its clean end and held results one clk later.
    task automatic check_done(input string nm, input logic [5:0] idx, input logic [31:0] arg,
                              input logic ce, input logic fe, input logic to);
        chk({nm, "_valid"}, 64'(resp_valid), 64'd1);
        chk({nm, "_index"}, 64'(resp_index), 64'(idx));
        chk({nm, "_arg"}, 64'(resp_arg), 64'(arg));
        chk({nm, "_crc_err"}, 64'(resp_crc_err), 64'(ce));
        chk({nm, "_frame_err"}, 64'(resp_frame_err), 64'(fe));
        chk({nm, "_timeout"}, 64'(resp_timeout), 64'(to));
        tick();
        chk({nm, "_valid_drop"}, 64'(resp_valid), 64'd0);
        chk({nm, "_busy_drop"}, 64'(busy), 64'd0);
        chk({nm, "_hold"}, 64'({resp_index, resp_arg}), 64'({idx, arg}));
    endtask

    typedef struct {
        string       nm;
        logic [47:0] frame;
        logic        skip;
        int          delay;
        int          maxgap;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic        crc_e;
        logic        frm_e;
    } vec_t;

    localparam logic [47:0] R7 = 48'h08_00_00_01_AA_13;

    initial begin
        vec_t vecs[5];
        logic seen;

        vecs[0] = '{"r7_ok",      R7,                   1'b0, 5, 0, 6'h08, 32'h000001AA, 1'b0, 1'b0};
        vecs[1] = '{"r7_bad_crc", 48'h08_00_00_01_AA_15, 1'b0, 3, 2, 6'h08, 32'h000001AA, 1'b1, 1'b0};
        vecs[2] = '{"r3_skip",    48'h3F_00_FF_80_00_FF, 1'b1, 0, 1, 6'h3F, 32'h00FF8000, 1'b0, 1'b0};
        vecs[3] = '{"end_bit",    48'h08_00_00_01_AA_12, 1'b0, 2, 0, 6'h08, 32'h000001AA, 1'b0, 1'b1};
        vecs[4] = '{"tx_bit",     48'h48_00_00_01_AA_13, 1'b1, 1, 2, 6'h08, 32'h000001AA, 1'b0, 1'b1};

        // Reset values.
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_outputs", 64'({resp_index, resp_timeout, resp_crc_err, resp_frame_err}) | 64'(resp_arg), 64'd0);
        rst = 1'b0;
        tick();

        // Fixed vectors.
        for (int v = 0; v < 5; v++) begin
            rx_frame(vecs[v].frame, vecs[v].skip, vecs[v].delay, vecs[v].maxgap);
            check_done(vecs[v].nm, vecs[v].idx, vecs[v].arg, vecs[v].crc_e & CRC_EN, vecs[v].frm_e, 1'b0);
        end

        // Timeout: 64 idle strobes, completion on exactly the 64th.
        do_arm(1'b0);
        for (int i = 0; i < 63; i++) strobe(1'b1, i % 2);
        chk("to_not_early", 64'(resp_valid), 64'd0);
        strobe(1'b1, 0);
        check_done("timeout", 6'h00, 32'h0, 1'b0, 1'b0, 1'b1);

        // Start bit on the 64th strobe beats the timeout.
        do_arm(1'b0);
        for (int i = 0; i < 63; i++) strobe(1'b1, 0);
        send_bits(R7, 47, 0, 0);
        check_done("start_on_64", 6'h08, 32'h000001AA, 1'b0, 1'b0, 1'b0);

        // arm mid-reception and in DONE is dropped.
        do_arm(1'b0);
        send_bits(R7, 47, 30, 0);
        arm = 1'b1; tick(); arm = 1'b0;
        send_bits(R7, 29, 0, 1);
        arm = 1'b1;
        check_done("arm_dropped", 6'h08, 32'h000001AA, 1'b0, 1'b0, 1'b0);
        arm = 1'b0;
        tick();
        chk("arm_in_done_ignored", 64'(busy), 64'd0);

        // Reset after 20 bits discards the partial response.
        do_arm(1'b0);
        send_bits(R7, 47, 28, 0);
        rst = 1'b1;
        #2;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_valid", 64'(resp_valid), 64'd0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 27; i >= 0; i--) begin
            strobe(R7[i], 0);
            if (resp_valid) seen = 1'b1;
        end
        tick();
        chk("rst_no_valid", 64'(seen | resp_valid | busy), 64'd0);
        rx_frame(R7, 1'b0, 4, 0);
        check_done("rearm_r7", 6'h08, 32'h000001AA, 1'b0, 1'b0, 1'b0);

        // Randomised frames against the reference model.
        for (int n = 0; n < 24; n++) begin
            logic [5:0]  idx;
            logic [31:0] arg;
            logic [39:0] msg;
            logic [47:0] f;
            logic        skip;
            logic        ce;
            logic        fe;
            int          kind;
            idx  = 6'($urandom);
            arg  = $urandom;
            msg  = {2'b00, idx, arg};
            f    = {msg, ref_crc7(msg), 1'b1};
            kind = int'($urandom_range(0, 3));
            if (kind == 1) f[1 + int'($urandom_range(0, 6))] ^= 1'b1;
            if (kind == 2) f[46] = 1'b1;
            if (kind == 3) f[0] = 1'b0;
            skip = 1'($urandom);
            fe   = f[46] | ~f[0];
            ce   = CRC_EN & ~skip & (ref_crc7(f[47:8]) != f[7:1]);
            rx_frame(f, skip, int'($urandom_range(0, 10)), int'($urandom_range(0, 2)));
            check_done("random", f[45:40], f[39:8], ce, fe, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
